seq_controller: RTL
===================

# seq_controller

Pattern sequencer for the LED display path. It steps a pattern-ROM read address through a selectable sequence on each tick from the throttle and captures the returned pattern word. It also services the sequence-up/down buttons. The block sits between the debouncers and throttle on one side and the dual-port pattern ROM on the other, and drives LEDR through `pattern`.

## Interface
Parameters:
- SEQ_W, 6: sequence-number width (64 sequences)
- STEP_W, 4: step-index width (up to 16 steps per sequence)
- DATA_W, 10: pattern word width
- ROM_LAT, 2: ROM read latency in clk_50 cycles, from address register to valid q

Ports:
- clk_50  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- step_tick  in  1  one-cycle pulse, already in clk_50 domain; requests the next step
- run  in  1  1 = advance on ticks; 0 = hold the current step
- seq_up  in  1  debounced level; each rising edge increments the pending sequence
- seq_dn  in  1  debounced level; each rising edge decrements the pending sequence
- len_last  in  STEP_W  index of the last step in a pass
- rom_addr  out  SEQ_W+STEP_W  registered, equals {seq_num, step}
- rom_q  in  DATA_W  ROM read data
- pattern  out  DATA_W  registered pattern word
- pattern_valid  out  1  one-cycle pulse when `pattern` updates
- seq_num  out  SEQ_W  active sequence
- seq_pend  out  SEQ_W  pending (selected) sequence
- step  out  STEP_W  current step
- wrap  out  1  one-cycle pulse when a pass completes

## Operation
- Button edges:
  - rise = in & ~prev.
  - prev registers reset to 1, so a button held through reset produces no edge.
  - If both rise in the same cycle, neither is applied.
  - seq_pend wraps modulo 2^SEQ_W: 63+1 → 0, 0−1 → 63.
- FSM states are FETCH and HOLD. Reset enters FETCH with rom_addr = 0.
- FETCH:
  - lat_cnt counts ROM_LAT+1 edges, then `pattern` ← rom_q and pattern_valid is pulsed.
  - Then → HOLD.
  - step_tick arriving in FETCH is dropped, not queued.
- HOLD, run=1, step_tick:
  - If step ≥ len_last: step ← 0, seq_num ← seq_pend, wrap pulses.
  - Otherwise step ← step+1.
  - rom_addr updates on the same edge; → FETCH.
- HOLD, run=0:
  - step_tick is ignored.
  - If seq_pend ≠ seq_num: seq_num ← seq_pend, step ← 0, rom_addr updates; → FETCH. The new sequence shows immediately while paused.
- With run=1, sequence changes take effect only at wrap.
- len_last is sampled live. If it drops below the current step, the next tick wraps.

## Timing
- Reset values:
  - 0: rom_addr, pattern, pattern_valid, seq_num, seq_pend, step, wrap, lat_cnt.
  - 1: both prev registers.
  - state = FETCH.
- First pattern_valid occurs on the (ROM_LAT+1)th rising edge after reset_n deasserts.
- Tick sampled on edge T in HOLD:
  - rom_addr and wrap change at T.
  - pattern and pattern_valid change at T+ROM_LAT+1.
- Minimum tick spacing for no drop is ROM_LAT+2 cycles.
- A seq edge is registered into seq_pend one cycle after the input rises.
- reset_n assertion clears all state asynchronously, including mid-FETCH. No partial capture reaches `pattern`.

## Structure
- Package seq_pkg holds:
  - SEQ_W, STEP_W, DATA_W defaults
  - state enum {FETCH, HOLD}
  - ADDR_W = SEQ_W+STEP_W
- Sub-module rise_detect (clk_50, reset_n, in, rise), instantiated for seq_up and seq_dn. Its prev register resets to 1.
- The ROM is external and is not instantiated here.

## Test plan
- Stimulus: reset; run=1; len_last=3; ROM model q=addr with latency 2; ticks every 8 cycles.
  - rom_addr runs 0,1,2,3,0.
  - wrap pulses on the 4th tick.
  - Each pattern equals the prior rom_addr, 3 edges after the tick.
- Stimulus: run=1; seq_up pulse at step 1.
  - seq_pend=1 after 1 cycle.
  - seq_num stays 0 until wrap, then rom_addr=0x010.
- Stimulus: run=0; seq_dn from 0.
  - seq_pend=63 and seq_num=63.
  - rom_addr=0x3F0, step=0, pattern_valid 3 edges later.
- Stimulus: seq_up and seq_dn rise together.
  - No change.
  - seq_up then held 1000 cycles: exactly one increment.
- Stimulus: second tick 2 cycles after the first.
  - Dropped; step advances once only.
- Stimulus: reset_n low mid-FETCH at step 5, seq 7.
  - All outputs 0 immediately.
  - After release, the first pattern_valid carries ROM word 0.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// seq_pkg: shared widths and FSM state type for the LED pattern sequencer.
package seq_pkg;
  localparam int SEQ_W  = 6;
  localparam int STEP_W = 4;
  localparam int DATA_W = 10;
  localparam int ADDR_W = SEQ_W + STEP_W;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/rise_detect.sv
`default_nettype none
// rise_detect: one-cycle rising-edge flag for a debounced button level.
module rise_detect (
  input  logic clk_50,
  input  logic reset_n,
  input  logic in,
  output logic rise
);
  logic prev;

  // prev resets high so a button held through reset never reports an edge
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) prev <= 1'b1;
    else          prev <= in;
  end

  assign rise = in & ~prev;
endmodule
`default_nettype wire

// File: rtl/seq_controller.sv
`default_nettype none
// seq_controller: steps the pattern-ROM address through the selected sequence on
// throttle ticks, captures the ROM word after its latency, and services seq buttons.
module seq_controller #(
  parameter int SEQ_W   = seq_pkg::SEQ_W,
  parameter int STEP_W  = seq_pkg::STEP_W,
  parameter int DATA_W  = seq_pkg::DATA_W,
  parameter int ROM_LAT = 2
) (
  input  logic                    clk_50,
  input  logic                    reset_n,
  input  logic                    step_tick,
  input  logic                    run,
  input  logic                    seq_up,
  input  logic                    seq_dn,
  input  logic [STEP_W-1:0]       len_last,
  output logic [SEQ_W+STEP_W-1:0] rom_addr,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [DATA_W-1:0]       pattern,
  output logic                    pattern_valid,
  output logic [SEQ_W-1:0]        seq_num,
  output logic [SEQ_W-1:0]        seq_pend,
  output logic [STEP_W-1:0]       step,
  output logic                    wrap
);
  import seq_pkg::*;

  localparam int LAT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             up_rise;
  logic             dn_rise;

  rise_detect u_rise_up (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .in      (seq_up),
    .rise    (up_rise)
  );

  rise_detect u_rise_dn (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .in      (seq_dn),
    .rise    (dn_rise)
  );

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= FETCH;
      lat_cnt       <= '0;
      rom_addr      <= '0;
      pattern       <= '0;
      pattern_valid <= 1'b0;
      seq_num       <= '0;
      seq_pend      <= '0;
      step          <= '0;
      wrap          <= 1'b0;
    end else begin
      pattern_valid <= 1'b0;
      wrap          <= 1'b0;

      // simultaneous presses cancel out
      if (up_rise && !dn_rise)      seq_pend <= seq_pend + SEQ_W'(1);
      else if (dn_rise && !up_rise) seq_pend <= seq_pend - SEQ_W'(1);

      case (state)
        FETCH: begin
          if (lat_cnt == LAT_W'(ROM_LAT)) begin
            pattern       <= rom_q;
            pattern_valid <= 1'b1;
            lat_cnt       <= '0;
            state         <= HOLD;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        HOLD: begin
          if (run) begin
            if (step_tick) begin
              // len_last is live, so a shrunken pass wraps on the next tick
              if (step >= len_last) begin
                step     <= '0;
                seq_num  <= seq_pend;
                rom_addr <= {seq_pend, {STEP_W{1'b0}}};
                wrap     <= 1'b1;
              end else begin
                step     <= step + STEP_W'(1);
                rom_addr <= {seq_num, step + STEP_W'(1)};
              end
              lat_cnt <= '0;
              state   <= FETCH;
            end
          end else if (seq_pend != seq_num) begin
            seq_num  <= seq_pend;
            step     <= '0;
            rom_addr <= {seq_pend, {STEP_W{1'b0}}};
            lat_cnt  <= '0;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end
endmodule
`default_nettype wire
